// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package mem_pkg;

   // Transaction sequencing states of the memory stage.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SACC = 2'd1,
      VACC = 2'd2,
      DONE = 2'd3
   } state_e;

   // Number of bus-width beats needed to move one vector register.
   function automatic int beats(input int v, input int n);
      return v / n;
   endfunction

endpackage

// File: rtl/beat_ctr.sv
// Beat counter for vector transfers: counts accepted beats, wraps to zero
// after the last one and flags when the current beat is the last.
module beat_ctr #(
   parameter int BEATS = 4,
   parameter int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic          clk,
   input  logic          rst,      // asynchronous, active low
   input  logic          inc_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          last_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign last_o = (cnt_q == CW'(BEATS - 1));
   assign cnt_o  = cnt_q;

   // Next count: clear wins, the last beat wraps back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: scalar word accesses in one bus beat, vector accesses as
// V/N consecutive word beats, stalling upstream until the result is ready.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int V = 128,
   parameter int N = 32,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst,        // asynchronous, active low
   input  logic         regw_M,
   input  logic         regmem_M,
   input  logic         memr_M,
   input  logic         memw_M,
   input  logic         vmem_M,
   input  logic [M-1:0] regScr_M,
   input  logic [N-1:0] ALUrslt_M,
   input  logic [N-1:0] wdata_M,
   input  logic [V-1:0] vdata_M,
   input  logic [N-1:0] mem_rdata,
   input  logic         mem_ready,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         stall,
   output logic         regw_o,
   output logic         regmem_o,
   output logic [M-1:0] regScr_o,
   output logic [N-1:0] ALUrslt_o,
   output logic [N-1:0] readdata_o,
   output logic [V-1:0] regVrslt_o
);

   localparam int BEATS = beats(V, N);
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_e          state_q;
   logic [CW-1:0]   cnt;
   logic            last_beat;
   logic            ctr_inc;
   logic            ctr_clr;
   logic            mem_op;
   logic            is_load;
   logic [N-1:0]    base_addr;
   logic [N-1:0]    beat_off;
   logic [N-1:0]    sbuf_q;
   logic [N-1:0]    vbuf_q [BEATS];
   logic [V-1:0]    vbuf_flat;
   logic [N-1:0]    vdata_slice [BEATS];
   logic [BEATS-1:0] vbuf_we;

   // Both strobes high is a store, so only a pure read request is a load.
   assign mem_op    = memr_M | memw_M;
   assign is_load   = memr_M & ~memw_M;
   assign base_addr = {ALUrslt_M[N-1:2], 2'b00};
   assign beat_off  = {{(N-CW-2){1'b0}}, cnt, 2'b00};

   assign regmem_o  = regmem_M;
   assign regScr_o  = regScr_M;
   assign ALUrslt_o = ALUrslt_M;

   beat_ctr #(
      .BEATS (BEATS),
      .CW    (CW)
   ) u_beat_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (ctr_inc),
      .clr_i  (ctr_clr),
      .cnt_o  (cnt),
      .last_o (last_beat)
   );

   // Per-beat slices of the vector: store data source and load buffers.
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
      assign vdata_slice[gi]          = vdata_M[gi*N +: N];
      assign vbuf_flat[gi*N +: N]     = vbuf_q[gi];
      assign vbuf_we[gi]              = (state_q == VACC) && mem_ready && is_load
                                        && (cnt == CW'(gi));

      // Load beat buffer: captures its beat when the bus completes it.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vbuf_q[gi] <= '0;
         end else if (vbuf_we[gi]) begin
            vbuf_q[gi] <= mem_rdata;
         end
      end
   end

   // Scalar load buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sbuf_q <= '0;
      end else if ((state_q == SACC) && mem_ready && is_load) begin
         sbuf_q <= mem_rdata;
      end
   end

   // Transaction sequencer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (mem_op) state_q <= vmem_M ? VACC : SACC;
            SACC: if (mem_ready) state_q <= DONE;
            VACC: if (mem_ready && last_beat) state_q <= DONE;
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Bus and pipeline outputs; bus request signals depend on state and
   // counter only, never on mem_ready.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = base_addr;
      mem_wdata  = wdata_M;
      stall      = 1'b0;
      regw_o     = regw_M;
      readdata_o = '0;
      regVrslt_o = vdata_M;
      ctr_inc    = 1'b0;
      ctr_clr    = 1'b0;
      case (state_q)
         IDLE: begin
            ctr_clr = 1'b1;
            if (mem_op) begin
               stall  = 1'b1;
               regw_o = 1'b0;
            end
         end
         SACC: begin
            mem_req = 1'b1;
            mem_we  = memw_M;
            stall   = 1'b1;
            regw_o  = 1'b0;
         end
         VACC: begin
            mem_req   = 1'b1;
            mem_we    = memw_M;
            mem_addr  = base_addr + beat_off;
            mem_wdata = vdata_slice[cnt];
            stall     = 1'b1;
            regw_o    = 1'b0;
            ctr_inc   = mem_ready;
         end
         DONE: begin
            readdata_o = sbuf_q;
            if (vmem_M && is_load) begin
               regVrslt_o = vbuf_flat;
            end
         end
         default: begin
            ctr_clr = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues operations and
// queues the expected bus beats and stage results; a monitor compares them.
module tb_mem_access_stage;

   localparam int V     = 128;
   localparam int N     = 32;
   localparam int M     = 4;
   localparam int BEATS = V / N;

   logic         clk = 1'b0;
   logic         rst;
   logic         regw_M, regmem_M, memr_M, memw_M, vmem_M;
   logic [M-1:0] regScr_M;
   logic [N-1:0] ALUrslt_M, wdata_M;
   logic [V-1:0] vdata_M;
   logic [N-1:0] mem_rdata;
   logic         mem_ready;
   logic         mem_req, mem_we;
   logic [N-1:0] mem_addr, mem_wdata;
   logic         stall;
   logic         regw_o, regmem_o;
   logic [M-1:0] regScr_o;
   logic [N-1:0] ALUrslt_o, readdata_o;
   logic [V-1:0] regVrslt_o;

   mem_access_stage #(.V(V), .N(N), .M(M)) dut (
      .clk        (clk),
      .rst        (rst),
      .regw_M     (regw_M),
      .regmem_M   (regmem_M),
      .memr_M     (memr_M),
      .memw_M     (memw_M),
      .vmem_M     (vmem_M),
      .regScr_M   (regScr_M),
      .ALUrslt_M  (ALUrslt_M),
      .wdata_M    (wdata_M),
      .vdata_M    (vdata_M),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .stall      (stall),
      .regw_o     (regw_o),
      .regmem_o   (regmem_o),
      .regScr_o   (regScr_o),
      .ALUrslt_o  (ALUrslt_o),
      .readdata_o (readdata_o),
      .regVrslt_o (regVrslt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   typedef struct {
      logic         regw;
      logic [31:0]  rdata;
      logic [127:0] vr;
      int           stalls;
      logic [3:0]   scr;
      logic [31:0]  alu;
      logic         regmem;
   } res_t;

   beat_t       beat_q [$];
   res_t        res_q  [$];
   int          wait_q [$];
   logic [31:0] mem [logic [31:0]];
   logic [31:0] sbuf_model;
   int          wt_cfg [BEATS];
   int          checks   = 0;
   int          failures = 0;
   bit          mon_en   = 1'b0;
   int          stall_cnt = 0;
   bit          resp_busy = 1'b0;
   int          cur_wait  = 0;

   // Word memory: written locations return stored data, others a hash of the address.
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Issue one operation (entered and left at posedge+1), queue its expectations.
   task automatic run_op(input logic [31:0] addr, input logic vmem, input logic rd,
                         input logic wr, input logic regw, input logic [127:0] vdata,
                         input logic [31:0] wdata);
      res_t        r;
      beat_t       b;
      logic [31:0] base;
      int          nb;
      int          n;
      regw_M    = regw;
      regmem_M  = rd;
      memr_M    = rd;
      memw_M    = wr;
      vmem_M    = vmem;
      regScr_M  = 4'($urandom);
      ALUrslt_M = addr;
      wdata_M   = wdata;
      vdata_M   = vdata;
      r.regw   = regw;
      r.scr    = regScr_M;
      r.alu    = addr;
      r.regmem = rd;
      r.vr     = vdata;
      r.rdata  = 32'h0;
      r.stalls = 0;
      if (rd || wr) begin
         base     = {addr[31:2], 2'b00};
         nb       = vmem ? BEATS : 1;
         r.stalls = 1;
         for (int k = 0; k < nb; k++) begin
            b.addr  = base + 32'(4 * k);
            b.we    = wr;
            b.wdata = vmem ? vdata[k*32 +: 32] : wdata;
            beat_q.push_back(b);
            wait_q.push_back(wt_cfg[k]);
            r.stalls += 1 + wt_cfg[k];
            if (wr) begin
               mem[b.addr] = b.wdata;
            end else if (vmem) begin
               r.vr[k*32 +: 32] = mem_rd(b.addr);
            end else begin
               sbuf_model = mem_rd(b.addr);
            end
         end
         r.rdata = sbuf_model;
      end
      res_q.push_back(r);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (stall && n < 200);
      if (stall) begin
         chk("op_timeout", 128'(stall), 128'(1'b0));
      end
      @(posedge clk);
      #1;
   endtask

   // Bus responder: inserts the queued wait cycles, then completes the beat.
   always @(posedge clk) begin
      #2;
      if (!rst || !mem_req) begin
         mem_ready = 1'b0;
         mem_rdata = $urandom;
      end else begin
         if (!resp_busy) begin
            cur_wait  = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            resp_busy = 1'b1;
         end
         if (cur_wait > 0) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            cur_wait--;
         end else begin
            mem_ready = 1'b1;
            mem_rdata = mem_rd(mem_addr);
            resp_busy = 1'b0;
         end
      end
   end

   // Monitor: compares each completed beat and each stage result.
   always @(negedge clk) begin
      if (mon_en) begin
         if (stall) begin
            stall_cnt++;
            chk("bubble_regw", 128'(regw_o), 128'(1'b0));
         end
         if (mem_req && mem_ready) begin
            if (beat_q.size() == 0) begin
               chk("unexpected_beat", 128'(mem_req), 128'(1'b0));
            end else begin
               beat_t b;
               b = beat_q.pop_front();
               chk("beat_addr", 128'(mem_addr), 128'(b.addr));
               chk("beat_we", 128'(mem_we), 128'(b.we));
               if (b.we) chk("beat_wdata", 128'(mem_wdata), 128'(b.wdata));
            end
         end
         if (!stall) begin
            if (res_q.size() == 0) begin
               chk("unexpected_result", 128'(stall), 128'(1'b1));
            end else begin
               res_t r;
               r = res_q.pop_front();
               chk("regw_o", 128'(regw_o), 128'(r.regw));
               chk("readdata_o", 128'(readdata_o), 128'(r.rdata));
               chk("regVrslt_o", regVrslt_o, r.vr);
               chk("regScr_o", 128'(regScr_o), 128'(r.scr));
               chk("ALUrslt_o", 128'(ALUrslt_o), 128'(r.alu));
               chk("regmem_o", 128'(regmem_o), 128'(r.regmem));
               chk("stall_cycles", 128'(stall_cnt), 128'(r.stalls));
               chk("req_idle", 128'(mem_req), 128'(1'b0));
               if (beat_q.size() != 0) chk("beats_left", 128'(beat_q.size()), 128'(0));
            end
            stall_cnt = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] vd;
      logic [31:0]  a;
      int           kind;
      rst = 1'b0;
      regw_M = 1'b0; regmem_M = 1'b0; memr_M = 1'b0; memw_M = 1'b0; vmem_M = 1'b0;
      regScr_M = '0; ALUrslt_M = '0; wdata_M = '0; vdata_M = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      sbuf_model = 32'h0;
      wt_cfg = '{0, 0, 0, 0};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall", 128'(stall), 128'(1'b0));
      chk("reset_req", 128'(mem_req), 128'(1'b0));
      chk("reset_readdata", 128'(readdata_o), 128'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Directed cases.
      run_op(32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b1, {4{32'hA5A5A5A5}}, 32'h0);
      mem[32'h100] = 32'hDEADBEEF;
      run_op(32'h0000_0103, 1'b0, 1'b1, 1'b0, 1'b1, {4{32'h1111_1111}}, 32'h0);
      mem[32'h200] = 32'd1; mem[32'h204] = 32'd2; mem[32'h208] = 32'd3; mem[32'h20C] = 32'd4;
      run_op(32'h0000_0200, 1'b1, 1'b1, 1'b0, 1'b1, {4{32'h2222_2222}}, 32'h0);
      wt_cfg = '{0, 2, 0, 0};
      run_op(32'h0000_0300, 1'b1, 1'b0, 1'b1, 1'b0,
             {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000}, 32'h0);
      wt_cfg = '{0, 0, 0, 0};
      run_op(32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 1'b1, {4{32'h3333_3333}}, 32'h0);
      run_op(32'h0000_0104, 1'b0, 1'b1, 1'b1, 1'b1, {4{32'h4444_4444}}, 32'h0BAD_F00D);

      // Randomized operations.
      for (int i = 0; i < 60; i++) begin
         for (int k = 0; k < BEATS; k++)
            wt_cfg[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         vd   = {$urandom, $urandom, $urandom, $urandom};
         a    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : (32'h1000 + 32'($urandom_range(0, 63)));
         kind = $urandom_range(0, 5);
         case (kind)
            0: run_op(a, 1'($urandom), 1'b0, 1'b0, 1'($urandom), vd, $urandom);
            1: run_op(a, 1'b0, 1'b1, 1'b0, 1'($urandom), vd, $urandom);
            2: run_op(a, 1'b0, 1'b0, 1'b1, 1'($urandom), vd, $urandom);
            3: run_op(a, 1'b1, 1'b1, 1'b0, 1'($urandom), vd, $urandom);
            4: run_op(a, 1'b1, 1'b0, 1'b1, 1'($urandom), vd, $urandom);
            default: run_op(a, 1'($urandom), 1'b1, 1'b1, 1'($urandom), vd, $urandom);
         endcase
      end

      // Reset during vector load beat 2.
      mon_en = 1'b0;
      wait_q.delete();
      regw_M = 1'b1; memr_M = 1'b1; memw_M = 1'b0; vmem_M = 1'b1; regmem_M = 1'b1;
      ALUrslt_M = 32'h0000_0400;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pre_req", 128'(mem_req), 128'(1'b1));
      rst = 1'b0;
      #1;
      chk("rst_req_drop", 128'(mem_req), 128'(1'b0));
      memr_M = 1'b0; vmem_M = 1'b0; regmem_M = 1'b0;
      vd = {4{32'h5A5A_0F0F}};
      vdata_M = vd;
      #1;
      chk("rst_stall", 128'(stall), 128'(1'b0));
      chk("rst_passthru", regVrslt_o, vd);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_stall", 128'(stall), 128'(1'b0));
      chk("post_rst_req", 128'(mem_req), 128'(1'b0));
      chk("post_rst_passthru", regVrslt_o, vd);
      beat_q.delete();
      res_q.delete();
      wait_q.delete();
      resp_busy  = 1'b0;
      cur_wait   = 0;
      sbuf_model = 32'h0;
      stall_cnt  = 0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      run_op(32'h0000_0300, 1'b0, 1'b0, 1'b1, 1'b0, {4{32'h6666_6666}}, 32'h7777_7777);
      run_op(32'h0000_0400, 1'b1, 1'b1, 1'b0, 1'b1, {4{32'h8888_8888}}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
